// File: rtl/bcd_serial_addsub_pkg.sv
//==============================================================================
// Module      : bcd_serial_addsub_pkg
// Description : Shared definitions for the digit-serial BCD adder/subtractor:
//               FSM state encoding, BCD constants and DIGITS range bounds.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bcd_serial_addsub_pkg;

  // Control FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Largest legal BCD digit and the decimal-adjust correction.
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_CORR  = 4'd6;

  // Legal range of the DIGITS parameter.
  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 16;

endpackage

`default_nettype wire

// File: rtl/bcd_serial_addsub_digit_add.sv
//==============================================================================
// Module      : bcd_digit_add
// Description : Combinational one-digit BCD adder with decimal adjust.
// Ports       : a_i, b_i [3:0] - operand digits
//               cin            - carry in
//               digit [3:0]    - corrected BCD sum digit
//               cout           - decimal carry out
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_digit_add
  import bcd_serial_addsub_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] w_z;
  logic       w_over;

  assign w_z    = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin};
  assign w_over = (w_z > {1'b0, DIGIT_MAX});

  // Adding 6 modulo 16 skips the six unused codes 10..15.
  assign digit = w_over ? (w_z[3:0] + BCD_CORR) : w_z[3:0];
  assign cout  = w_over;

endmodule

`default_nettype wire

// File: rtl/bcd_serial_addsub.sv
//==============================================================================
// Module      : bcd_serial_addsub
// Description : Digit-serial packed-BCD adder/subtractor. One digit per clock,
//               least significant digit first, through a single shared
//               one-digit adder. Subtraction adds the 9's complement of B with
//               an initial carry of 1.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start, sub          - request / operation select (1 = A-B)
//               a, b [4*DIGITS-1:0] - packed BCD operands, digit 0 in [3:0]
//               busy, done          - in progress / one-cycle completion
//               result              - packed BCD result (held until next done)
//               cout                - carry (add) or borrow (sub)
//               err                 - an operand digit was above 9
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_serial_addsub
  import bcd_serial_addsub_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                err
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] c_last_idx = IDXW'(DIGITS - 1);

  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_digits_range
    $error("bcd_serial_addsub: DIGITS outside 1..16");
  end

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sub;
  logic            r_carry;
  logic            r_err_pend;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_result;
  logic            r_cout;
  logic            r_err;

  logic            w_accept;
  logic            w_last;
  logic [3:0]      w_digit;
  logic            w_dcout;
  logic [W-1:0]    w_acc_next;
  logic [W-1:0]    w_b_cap;
  logic            w_bad;

  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_state == ST_RUN) && (r_idx == c_last_idx);

  // Operand screening and B preparation at accept time.
  always_comb begin
    w_b_cap = b;
    w_bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > DIGIT_MAX) || (b[4*i +: 4] > DIGIT_MAX)) begin
        w_bad = 1'b1;
      end
      if (sub) begin
        w_b_cap[4*i +: 4] = DIGIT_MAX - b[4*i +: 4];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and status outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (r_idx == c_last_idx) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = start ? ST_RUN : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  bcd_digit_add u_digit_add (
    .a_i   (r_a[3:0]),
    .b_i   (r_b[3:0]),
    .cin   (r_carry),
    .digit (w_digit),
    .cout  (w_dcout)
  );

  // Partial result: corrected digits enter at the MSD end, so after the last
  // digit the LSD has been shifted down to bits [3:0].
  if (DIGITS > 1) begin : g_acc_multi
    logic [W-5:0] r_acc;

    assign w_acc_next = {w_digit, r_acc};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
      end else if (w_accept) begin
        r_acc <= '0;
      end else if (r_state == ST_RUN) begin
        r_acc <= w_acc_next[W-1:4];
      end
    end
  end else begin : g_acc_single
    assign w_acc_next = w_digit;
  end

  // Operand shift registers, carry chain and published outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_err_pend <= 1'b0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_a        <= a;
      r_b        <= w_b_cap;
      r_sub      <= sub;
      r_carry    <= sub;
      r_idx      <= '0;
      r_err_pend <= w_bad;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      r_carry <= w_dcout;
      if (w_last) begin
        r_idx    <= '0;
        r_err    <= r_err_pend;
        r_result <= r_err_pend ? '0 : w_acc_next;
        // In subtract mode a missing final carry means A < B.
        r_cout   <= r_err_pend ? 1'b0 : (w_dcout ^ r_sub);
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;
  assign err    = r_err;

endmodule

`default_nettype wire

// File: doc/bcd_serial_addsub.md
BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the operand width in BCD digits; legal range 1..16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request an operation; sampled on the rising edge.
REQ-005 sub  input  1  SHALL select the operation: 0 = A+B, 1 = A-B; sampled with start.
REQ-006 a  input  4*DIGITS  SHALL be operand A, packed BCD, digit 0 in bits [3:0].
REQ-007 b  input  4*DIGITS  SHALL be operand B, packed BCD, same packing as a.
REQ-008 busy  output  1  SHALL be high while an operation is in progress.
REQ-009 done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 result  output  4*DIGITS  SHALL be the packed BCD result.
REQ-011 cout  output  1  SHALL be the carry-out for add and the borrow for sub.
REQ-012 err  output  1  SHALL flag an invalid input digit (>9) in the accepted operands.

Function
REQ-013 FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL capture a, b and sub, clear the digit index and carry, and move to RUN.
- For sub=1, the capture SHALL store the 9's complement of each B digit and set the initial carry to 1.
REQ-015 start in RUN SHALL be ignored; captured operands SHALL NOT change.
REQ-016 RUN SHALL process one digit per edge, LSD first:
- binary sum z = a_i + b_i + c;
- corrected digit = z+6 (mod 16) when z>9;
- carry c = 1 when z>9.
REQ-017 The digit index SHALL wrap at DIGITS-1: after that digit, the FSM moves to DONE.
- Latency: accept at edge 0, last digit at edge DIGITS, done high during the cycle after edge DIGITS.
REQ-018 DONE SHALL last one cycle, then return to IDLE unless start=1 (back-to-back accept, REQ-014).
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-020 Add: cout SHALL equal the final carry.
REQ-021 Sub: cout SHALL equal the inverse of the final carry (1 means A<B); result SHALL be (A-B) mod 10^DIGITS.
REQ-022 err SHALL be evaluated on all captured digits of a and b at accept and registered.
- When err=1, result SHALL be forced to all zeros and cout to 0 at DONE; timing SHALL be unchanged.
REQ-023 result, cout and err SHALL hold their values from DONE until the next DONE.
- result SHALL NOT be visible as a partial sum outside RUN.

Reset
REQ-024 While rst_n=0, outputs and state SHALL be:
- state = IDLE; busy = 0; done = 0; result = 0; cout = 0; err = 0;
- operand registers, digit index and carry = 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-026 Deassertion SHALL be synchronous to clk (external synchroniser); the first accept is legal on the first edge after deassertion.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state encoding (2-bit);
- BCD constants: DIGIT_MAX = 9, BCD_CORR = 6;
- the DIGITS legal-range bounds.
REQ-028 Sub-module bcd_digit_add SHALL be the combinational one-digit adder (a_i, b_i, cin -> digit, cout), instantiated once and time-multiplexed across digits.
REQ-029 Operands SHALL be shifted right one digit per RUN cycle.
- result SHALL be assembled by shifting corrected digits in at the MSD end.

Verification (DIGITS=4)
REQ-030 Add: a=1234, b=5678 -> result=6912, cout=0, err=0; done 4 cycles after the accept edge.
REQ-031 Add wrap: a=9999, b=0001 -> result=0000, cout=1.
REQ-032 Sub no borrow: a=0500, b=0123 -> result=0377, cout=0.
- Sub borrow: a=0123, b=0500 -> result=9623, cout=1.
REQ-033 Invalid digit: a=0x12A4, b=0001 -> err=1, result=0000, cout=0; done timing unchanged.
REQ-034 Protocol:
- start pulsed during RUN -> ignored, first result intact;
- start held high through DONE -> second operation accepted back-to-back, busy low for exactly one cycle.
REQ-035 Reset: rst_n low at the second RUN cycle -> all outputs 0 immediately, no done pulse, IDLE after release.
